// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame constants and parity helper for the PS/2 device
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, TX_HI, TX_LO, RX_START, RX_LO, RX_HI, DONE} state_t;
    localparam int FRAME_LEN = 11;
    localparam int HALF_CYC_DEF = 1250;
    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_half_timer.sv
// ps2_half_timer: half-period down-counter, expire is high while the count sits at zero
module ps2_half_timer import ps2_pkg::*; #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expire = (cnt == '0);
endmodule

// File: rtl/ps2_device.sv
// ps2_device: PS/2 device-side link, sends bytes to the host and receives host commands
module ps2_device import ps2_pkg::*; #(
    parameter int HALF_CYC = HALF_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_stb,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_abort,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err
);
    state_t state;
    logic [3:0] bit_cnt;
    logic [FRAME_LEN-1:0] sh;
    logic rts, accept, load, expire, last_bit, rx_good;
    assign rts = ps2_clk_in & ~ps2_data_in;
    assign tx_ready = (state == IDLE) & ~rts;
    assign accept = tx_stb & tx_ready & ps2_clk_in;
    assign last_bit = (bit_cnt == 4'(FRAME_LEN - 1));
    // after ten RX samples: sh[10]=stop, sh[9]=parity, sh[8:1]=data
    assign rx_good = sh[10] & (^sh[9:1]);
    assign load = (state == IDLE) ? (rts | accept) : (expire & (state != DONE));
    ps2_half_timer #(.W(16)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_val(16'(HALF_CYC - 1)),
        .expire(expire)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done <= 1'b0;
            tx_abort <= 1'b0;
            rx_valid <= 1'b0;
            rx_err <= 1'b0;
            rx_data <= '0;
            bit_cnt <= '0;
            sh <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_abort <= 1'b0;
            rx_valid <= 1'b0;
            rx_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (rts) state <= RX_START;
                    else if (accept) begin
                        state <= TX_HI;
                        sh <= {1'b1, odd_par(tx_data), tx_data, 1'b0};
                        ps2_data_oe <= 1'b1;
                    end
                end
                TX_HI: if (expire) begin
                    if (!ps2_clk_in) begin
                        state <= IDLE;
                        ps2_data_oe <= 1'b0;
                        tx_abort <= 1'b1;
                    end else begin
                        state <= TX_LO;
                        ps2_clk_oe <= 1'b1;
                    end
                end
                TX_LO: if (expire) begin
                    ps2_clk_oe <= 1'b0;
                    if (last_bit) begin
                        state <= DONE;
                        ps2_data_oe <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        state <= TX_HI;
                        bit_cnt <= bit_cnt + 4'd1;
                        sh <= sh >> 1;
                        ps2_data_oe <= ~sh[1];
                    end
                end
                RX_START: if (expire) begin
                    state <= RX_LO;
                    ps2_clk_oe <= 1'b1;
                end
                RX_LO: if (expire) begin
                    state <= RX_HI;
                    ps2_clk_oe <= 1'b0;
                end
                RX_HI: if (expire) begin
                    if (!ps2_clk_in) begin
                        state <= IDLE;
                        ps2_data_oe <= 1'b0;
                    end else if (last_bit) begin
                        state <= DONE;
                        ps2_data_oe <= 1'b0;
                        rx_valid <= rx_good;
                        rx_err <= ~rx_good;
                        if (rx_good) rx_data <= sh[8:1];
                    end else begin
                        state <= RX_LO;
                        ps2_clk_oe <= 1'b1;
                        bit_cnt <= bit_cnt + 4'd1;
                        sh <= {ps2_data_in, sh[10:1]};
                        // the stop bit sample decides whether pulse 11 carries the ack
                        if (bit_cnt == 4'd9) ps2_data_oe <= ps2_data_in;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ps2_device.md
PS2_DEVICE -- requirements
Module: ps2_device

Interface
REQ-001 SHALL have parameter HALF_CYC, default 1250, meaning clk cycles per PS/2 clock half-period; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ps2_clk_in  input  1  sensed PS/2 clock line, already filtered upstream.
REQ-005 SHALL have port ps2_data_in  input  1  sensed PS/2 data line, already filtered upstream.
REQ-006 SHALL have port ps2_clk_oe  output  1  1 = pull clock line low; 0 = release.
REQ-007 SHALL have port ps2_data_oe  output  1  1 = pull data line low; 0 = release.
REQ-008 SHALL have port tx_stb  input  1  one-cycle request to send tx_data to the host.
REQ-009 SHALL have port tx_data  input  8  byte to send; sampled only in the tx_stb cycle.
REQ-010 SHALL have port tx_ready  output  1  high only in IDLE with no host request pending.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse when a frame is sent completely.
REQ-012 SHALL have port tx_abort  output  1  one-cycle pulse when the host inhibits a frame.
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse; rx_data holds a good host byte.
REQ-014 SHALL have port rx_data  output  8  last received host byte; held until the next reception.
REQ-015 SHALL have port rx_err  output  1  one-cycle pulse on host-frame parity or stop error.

Function
REQ-016 SHALL use the FSM states IDLE, TX_HI, TX_LO, RX_START, RX_LO, RX_HI, DONE, each timed by one half-period down-counter reloaded to HALF_CYC-1.
REQ-017 IDLE: a host request-to-send (ps2_data_in=0 and ps2_clk_in=1) SHALL go to RX_START; otherwise an accepted tx_stb SHALL go to TX_HI.
REQ-018 If a request-to-send and tx_stb occur in the same cycle, the request SHALL win; tx_stb SHALL be dropped with no tx_done or tx_abort.
REQ-019 A tx_stb SHALL be accepted only in a cycle where tx_ready=1 and ps2_clk_in=1; otherwise it SHALL be ignored.
REQ-020 TX SHALL load an 11-bit LSB-first frame: start 0, tx_data[0..7], odd parity, stop 1.
REQ-021 TX_HI SHALL last HALF_CYC cycles: clock released, ps2_data_oe = NOT current bit.
REQ-022 TX_LO SHALL last HALF_CYC cycles with ps2_clk_oe=1 and the data bit held, then shift to the next bit.
REQ-023 In the last cycle of each TX_HI, if ps2_clk_in=0 (host inhibit), the FSM SHALL release both lines next cycle, pulse tx_abort, and return to IDLE; the byte SHALL be discarded.
REQ-024 After the 11th TX_LO, the FSM SHALL release both lines and pulse tx_done, exactly 22*HALF_CYC+1 cycles after the accepting tx_stb cycle.
REQ-025 RX_START SHALL wait HALF_CYC cycles with both lines released.
REQ-026 RX SHALL then produce 11 clock pulses, each RX_LO (ps2_clk_oe=1) then RX_HI (released), each HALF_CYC cycles long.
REQ-027 In the last cycle of RX_HI for pulses 1..10, RX SHALL sample ps2_data_in into data[0..7], parity, stop.
REQ-028 During pulse 11, ps2_data_oe SHALL be 1 (ack) only if the stop bit sampled 1; it SHALL release at the end of that RX_HI.
REQ-029 On RX completion, a good frame (odd parity over 9 bits and stop=1) SHALL update rx_data and pulse rx_valid; otherwise rx_err SHALL pulse and rx_data SHALL be unchanged.
REQ-030 Host inhibit during RX (clock low in the last RX_HI cycle) SHALL abort to IDLE silently, with no rx pulse.
REQ-031 DONE SHALL last one cycle and carry the completion pulse; IDLE SHALL follow.

Reset
REQ-032 While rst=1: state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=tx_abort=rx_valid=rx_err=0, rx_data=0x00, counter=0.
REQ-033 Reset mid-frame SHALL release both lines in the first cycle rst is sampled and discard any partial frame.
REQ-034 tx_ready SHALL be 1 in the first cycle after reset when no host request is present.

Structure
REQ-035 Package ps2_pkg SHALL hold the state enum, the frame-length constant 11, HALF_CYC default, and the odd-parity function.
REQ-036 The half-period counter SHALL be a sub-module ps2_half_timer (load, tick/expire, width 16); all other logic SHALL be in ps2_device.

Verification (HALF_CYC=8)
REQ-037 tx_stb with tx_data=0x1C -> line bits 0,0,0,1,1,1,0,0,0,0,1, and tx_done at stb cycle +177.
REQ-038 Host sends 0xED with parity 1 and stop 1 -> ack low during pulse 11, rx_valid, rx_data=0xED.
REQ-039 Host sends 0xED with parity 0 -> ack still driven, rx_err pulse, rx_data unchanged, no rx_valid.
REQ-040 Host holds clock low during TX bit 4 -> tx_abort pulse, both oe=0 next cycle, no tx_done.
REQ-041 Request-to-send in the same cycle as tx_stb=1 (0x55) -> RX frame serviced, no tx_done or tx_abort.
REQ-042 rst asserted during RX pulse 5 -> both oe=0 while rst=1, no rx_valid or rx_err, tx_ready=1 after reset.
